// File: rtl/au_log2_seq_pkg.sv
// Shared definitions for the fixed-point log2 unit and the integer-log2 stage.
// Latency: n/a (package only).
// Backpressure: n/a.
package au_log2_seq_pkg;

    // max(ceil(log2(x)), 1); also sizes the integer-log2 stage upstream.
    function automatic int clogb2(input int x);
        int r;
        r = 0;
        for (int v = x - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/au_lz_norm.sv
// Leading-one index and left-shift normalizer (mantissa in 1.(WIDTH-1) format).
// Latency: combinational.
// Backpressure: none; pure function of a.
// Ports: a (operand), k (index of highest set bit, 0 when a==0), m (a << (WIDTH-1-k)).
module au_lz_norm
    import au_log2_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IW    = clogb2(WIDTH)
) (
    input  logic [WIDTH-1:0] a,
    output logic [IW-1:0]    k,
    output logic [WIDTH-1:0] m
);

    logic [IW-1:0] shamt;

    always_comb begin
        k = '0;
        // Ascending scan: the last hit is the highest set bit.
        for (int i = 0; i < WIDTH; i++) begin
            if (a[i]) begin
                k = IW'(i);
            end
        end
        // WIDTH-1 always fits in IW bits, so the subtraction never wraps.
        shamt = IW'(WIDTH - 1) - k;
        m     = a << shamt;
    end

endmodule

// File: rtl/au_log2_seq.sv
// Sequential fixed-point log2: z = floor(log2 a).FRAC fraction bits, one bit per clock.
// Latency: accept -> NORM (1) -> ITER (FRAC) -> DONE; a==0 skips ITER.
// Backpressure: single operand in flight; DONE holds z/zero until out_ready, in_ready only in IDLE.
// Ports: clk, rst (sync, active-high), in_valid/in_ready/a (operand handshake),
//        out_valid/out_ready/z/zero (result handshake; z is IW.FRAC unsigned, zero flags a==0).
module au_log2_seq
    import au_log2_seq_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int FRAC  = 4,
    localparam int IW    = clogb2(WIDTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    a,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [IW+FRAC-1:0]  z,
    output logic                zero
);

    localparam int CW = clogb2(FRAC);

    if (WIDTH < 1 || FRAC < 1) begin : g_bad_param
        $fatal(1, "au_log2_seq: WIDTH and FRAC must both be >= 1");
    end

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   m_q;
    logic [WIDTH-1:0]   norm_m;
    logic [IW-1:0]      norm_k;
    logic [IW-1:0]      int_q;
    logic [FRAC-1:0]    frac_q;
    logic [CW-1:0]      cnt_q;
    logic               zero_q;
    logic [2*WIDTH-1:0] sq;
    logic [2*WIDTH-1:0] sq_sh;
    logic               last_iter;
    logic               unused_sq_lsbs;

    au_lz_norm #(
        .WIDTH (WIDTH),
        .IW    (IW)
    ) u_norm (
        .a (a_q),
        .k (norm_k),
        .m (norm_m)
    );

    // m in [1,2) so m*m in [1,4). If the square reached 2, that is a fraction
    // bit of 1 and we renormalise by taking the top half; otherwise shift one
    // left first. Low bits are simply dropped (truncation).
    assign sq             = {{WIDTH{1'b0}}, m_q} * {{WIDTH{1'b0}}, m_q};
    assign sq_sh          = sq[2*WIDTH-1] ? sq : (sq << 1);
    assign unused_sq_lsbs = ^sq_sh[WIDTH-1:0];
    assign last_iter      = (cnt_q == CW'(FRAC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = NORM;
                end
            end
            NORM: begin
                state_nxt = (a_q == '0) ? DONE : ITER;
            end
            ITER: begin
                if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // a_q, m_q and cnt_q carry no reset: they are always rewritten before use.
    always_ff @(posedge clk) begin
        if (rst) begin
            int_q  <= '0;
            frac_q <= '0;
            zero_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q <= a;
                    end
                end
                NORM: begin
                    zero_q <= (a_q == '0);
                    int_q  <= (a_q == '0) ? '0 : norm_k;
                    frac_q <= '0;
                    cnt_q  <= '0;
                    m_q    <= norm_m;
                end
                ITER: begin
                    frac_q <= (frac_q << 1) | FRAC'(sq[2*WIDTH-1]);
                    m_q    <= sq_sh[2*WIDTH-1:WIDTH];
                    cnt_q  <= cnt_q + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign z    = {int_q, frac_q};
    assign zero = zero_q;

endmodule

// File: tb/tb_au_log2_seq.sv
// Directed and swept checks of au_log2_seq at WIDTH=8, FRAC=4.
// Latency is counted in negedges after the accept edge (NORM is cycle 1).
// Outputs are sampled on the falling edge, inputs driven there too.
module tb_au_log2_seq;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       in_valid  = 1'b0;
    logic       in_ready;
    logic [7:0] a         = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [6:0] z;
    logic       zero;

    int checks = 0;
    int errors = 0;

    au_log2_seq #(
        .WIDTH (8),
        .FRAC  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Independent reference: truncating square iteration on 8-bit mantissa.
    function automatic logic [6:0] ref_log2(input logic [7:0] av);
        int          k;
        logic [7:0]  m;
        logic [15:0] s;
        logic [3:0]  f;
        k = 0;
        f = 4'h0;
        if (av == 8'h00) return 7'h00;
        for (int i = 7; i >= 0; i--) begin
            if (av[i] && k == 0 && (av >> i) == 8'h01) k = i;
        end
        m = av << (7 - k);
        for (int j = 3; j >= 0; j--) begin
            s = {8'h00, m} * {8'h00, m};
            if (s[15]) begin
                f[j] = 1'b1;
                m    = s[15:8];
            end else begin
                f[j] = 1'b0;
                m    = s[14:7];
            end
        end
        return {k[2:0], f};
    endfunction

    // Starts at a negedge in IDLE, returns at the negedge where out_valid is first seen.
    task automatic op_check(input logic [7:0] av, input logic [6:0] exp_z, input logic exp_zero,
                            input int exp_lat, input string tag, input bit rnd_rdy);
        int lat;
        @(negedge clk);
        chk({tag, "_in_ready"}, in_ready, 1);
        in_valid = 1'b1;
        a        = av;
        @(negedge clk);
        in_valid = 1'b0;
        a        = 8'($urandom);
        lat      = 1;
        while (!out_valid && lat < 40) begin
            if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_z"}, z, exp_z);
        chk({tag, "_zero"}, zero, exp_zero);
    endtask

    // Holds out_ready low for delay cycles checking stability, then handshakes.
    task automatic handshake(input int delay, input logic [6:0] exp_z, input logic exp_zero,
                             input string tag);
        out_ready = 1'b0;
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, out_valid, 1);
            chk({tag, "_hold_z"}, z, exp_z);
            chk({tag, "_hold_zero"}, zero, exp_zero);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_post_valid"}, out_valid, 0);
        chk({tag, "_post_in_ready"}, in_ready, 1);
    endtask

    initial begin
        logic [7:0] av;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_z", z, 0);
        chk("rst_zero", zero, 0);
        rst = 1'b0;

        // Directed vectors (hand-computed)
        op_check(8'd22, 7'b100_0111, 1'b0, 6, "a22", 1'b0);
        handshake(0, 7'b100_0111, 1'b0, "a22");
        op_check(8'h80, 7'b111_0000, 1'b0, 6, "a80", 1'b0);
        handshake(1, 7'b111_0000, 1'b0, "a80");
        op_check(8'h01, 7'b000_0000, 1'b0, 6, "a01", 1'b0);
        handshake(0, 7'b000_0000, 1'b0, "a01");
        op_check(8'hFF, 7'b111_1111, 1'b0, 6, "aFF", 1'b0);
        handshake(0, 7'b111_1111, 1'b0, "aFF");
        op_check(8'h00, 7'b000_0000, 1'b1, 2, "a00", 1'b0);
        handshake(0, 7'b000_0000, 1'b1, "a00");
        op_check(8'h10, 7'b100_0000, 1'b0, 6, "a10", 1'b0);
        handshake(0, 7'b100_0000, 1'b0, "a10");

        // Backpressure: 10 cycles stalled, in_valid pulses must be ignored
        op_check(8'd22, 7'b100_0111, 1'b0, 6, "bp", 1'b0);
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = (i % 2 == 0);
            a        = 8'h80;
            @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_z", z, 7'b100_0111);
            chk("bp_zero", zero, 0);
            chk("bp_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        handshake(0, 7'b100_0111, 1'b0, "bp");
        repeat (3) @(negedge clk);
        chk("bp_no_queue_valid", out_valid, 0);
        chk("bp_no_queue_in_ready", in_ready, 1);
        chk("bp_no_queue_z", z, 7'b100_0111);

        // Reset mid-ITER
        in_valid = 1'b1;
        a        = 8'd22;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_z", z, 0);
        chk("midrst_zero", zero, 0);
        op_check(8'h80, 7'b111_0000, 1'b0, 6, "after_rst", 1'b0);
        handshake(0, 7'b111_0000, 1'b0, "after_rst");

        // Sweep of all operands with random gaps and out_ready
        for (int i = 0; i < 256; i++) begin
            av = i[7:0];
            repeat ($urandom_range(0, 2)) @(negedge clk);
            op_check(av, ref_log2(av), (av == 8'h00), (av == 8'h00) ? 2 : 6, "sweep", 1'b1);
            handshake($urandom_range(0, 2), ref_log2(av), (av == 8'h00), "sweep");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
